// File: rtl/jk_bank_sched_pkg.sv
// ============================================================================
// Module   : jk_bank_sched_pkg
// Brief    : Shared types and the op-to-JK decode for the JK bank scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

package jk_bank_sched_pkg;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_RESET  = 2'b01,
        OP_SET    = 2'b10,
        OP_TOGGLE = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    // Returns {j,k} for one bit whose mask is set.
    function automatic logic [1:0] op_to_jk(input op_e op);
        logic [1:0] jk;
        case (op)
            OP_HOLD:   jk = 2'b00;
            OP_RESET:  jk = 2'b01;
            OP_SET:    jk = 2'b10;
            OP_TOGGLE: jk = 2'b11;
            default:   jk = 2'b00;
        endcase
        return jk;
    endfunction

endpackage

`default_nettype wire

// File: rtl/jk_bank.sv
// ============================================================================
// Module   : jk_bank
// Brief    : W independent rising-edge JK flip-flops with async active-low reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module jk_bank #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] j,
    input  logic [W-1:0] k,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= (j & ~q) | (~k & q);
        end
    end

endmodule

`default_nettype wire

// File: rtl/jk_bank_sched.sv
// ============================================================================
// Module   : jk_bank_sched
// Brief    : Arbitrates NREQ JK commands onto one shared JK bank, 3 cycles each.
//            Define JK_BANK_SCHED_FIXED_PRI_EN for lowest-index-wins priority
//            instead of round-robin.
// Revision : 1.0
// ============================================================================
`default_nettype none

module jk_bank_sched
    import jk_bank_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [2*NREQ-1:0]        req_op,
    input  logic [W*NREQ-1:0]        req_mask,
    output logic [W-1:0]             j_out,
    output logic [W-1:0]             k_out,
    output logic [W-1:0]             q,
    output logic                     resp_valid,
    output logic [$clog2(NREQ)-1:0]  resp_id,
    output logic [W-1:0]             resp_q
);

    localparam int IDW = $clog2(NREQ);

    state_e          r_state;
    state_e          w_state_nxt;
    op_e             r_op;
    logic [W-1:0]    r_mask;
    logic [IDW-1:0]  r_id;

    logic            w_found;
    logic            w_hs;
    logic [IDW-1:0]  w_gnt;
    logic [1:0]      w_sel_op;
    logic [W-1:0]    w_sel_mask;
    logic [NREQ-1:0] w_upper;
    logic [1:0]      w_jk;

    // w_upper marks requesters at or above the search start.
`ifdef JK_BANK_SCHED_FIXED_PRI_EN
    assign w_upper = '1;
`else
    logic [IDW-1:0] r_ptr;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_upper
        assign w_upper[gi] = (r_ptr <= IDW'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_hs) begin
            r_ptr <= (w_gnt == IDW'(NREQ - 1)) ? '0 : w_gnt + IDW'(1);
        end
    end
`endif

    // Wrap-around search: lowest valid index overall, overridden by the
    // lowest valid index at or above the start point if one exists.
    always_comb begin
        w_found    = |req_valid;
        w_gnt      = '0;
        w_sel_op   = '0;
        w_sel_mask = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req_valid[j]) begin
                w_gnt      = IDW'(j);
                w_sel_op   = req_op[2*j +: 2];
                w_sel_mask = req_mask[W*j +: W];
            end
        end
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req_valid[j] && w_upper[j]) begin
                w_gnt      = IDW'(j);
                w_sel_op   = req_op[2*j +: 2];
                w_sel_mask = req_mask[W*j +: W];
            end
        end
    end

    assign w_hs = (r_state == ST_IDLE) && w_found;
    assign w_jk = op_to_jk(r_op);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= OP_HOLD;
            r_mask <= '0;
            r_id   <= '0;
        end else if (w_hs) begin
            r_op   <= op_e'(w_sel_op);
            r_mask <= w_sel_mask;
            r_id   <= w_gnt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        j_out       = '0;
        k_out       = '0;
        resp_valid  = 1'b0;
        resp_id     = '0;
        resp_q      = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    req_ready   = NREQ'(1) << w_gnt;
                    w_state_nxt = ST_APPLY;
                end
            end
            ST_APPLY: begin
                j_out       = r_mask & {W{w_jk[1]}};
                k_out       = r_mask & {W{w_jk[0]}};
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                resp_valid  = 1'b1;
                resp_id     = r_id;
                resp_q      = q;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    jk_bank #(
        .W (W)
    ) u_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .j     (j_out),
        .k     (k_out),
        .q     (q)
    );

endmodule

`default_nettype wire

// File: tb/tb_jk_bank_sched.sv
// ============================================================================
// Module   : tb_jk_bank_sched
// Brief    : Directed and random checks of jk_bank_sched against a transaction model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_jk_bank_sched;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] RST  = 2'b01;
    localparam logic [1:0] SET  = 2'b10;
    localparam logic [1:0] TOG  = 2'b11;

    logic             clk;
    logic             rst_n;
    logic [NREQ-1:0]  req_valid;
    logic [NREQ-1:0]  req_ready;
    logic [2*NREQ-1:0] req_op;
    logic [W*NREQ-1:0] req_mask;
    logic [W-1:0]     j_out;
    logic [W-1:0]     k_out;
    logic [W-1:0]     q;
    logic             resp_valid;
    logic [1:0]       resp_id;
    logic [W-1:0]     resp_q;

    jk_bank_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_mask   (req_mask),
        .j_out      (j_out),
        .k_out      (k_out),
        .q          (q),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_q     (resp_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester-side state
    logic [NREQ-1:0] vld;
    logic [1:0]      opa  [NREQ];
    logic [W-1:0]    mska [NREQ];

    assign req_valid = vld;
    always_comb begin
        req_op   = '0;
        req_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_op[2*i +: 2]   = opa[i];
            req_mask[W*i +: W] = mska[i];
        end
    end

    // Transaction-level model state
    int         total = 0;
    int         bad   = 0;
    int         cyc, next_free, apply_cyc, resp_cyc, ptr, drop_g;
    logic [7:0] qm, exp_j, exp_k, exp_qn;
    int         exp_id;
    bit         keep_all, rnd_mode;
    logic [1:0] last_resp_id;
    logic [7:0] last_resp_q;
    int         gq[$];
    int         gc[$];
    int         exp_order[5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int arb(input logic [NREQ-1:0] v, input int p);
        int s;
`ifdef JK_BANK_SCHED_FIXED_PRI_EN
        s = 0;
`else
        s = p;
`endif
        for (int k = 0; k < NREQ; k++)
            if (v[(s + k) % NREQ]) return (s + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [7:0] bank_after(input logic [7:0] qo, input logic [1:0] op, input logic [7:0] m);
        case (op)
            RST:     return qo & ~m;
            SET:     return qo | m;
            TOG:     return qo ^ m;
            default: return qo;
        endcase
    endfunction

    // One clock: check mid-cycle at negedge, then drive requester changes just after posedge.
    task automatic cycle();
        logic [NREQ-1:0] exp_ready;
        int g;
        @(negedge clk);
        exp_ready = '0;
        g = -1;
        if (cyc >= next_free && vld != '0) begin
            g = arb(vld, ptr);
            exp_ready = NREQ'(1) << g;
        end
        chk("req_ready", req_ready, exp_ready);
        chk("j_out", j_out, (cyc == apply_cyc) ? exp_j : 8'h00);
        chk("k_out", k_out, (cyc == apply_cyc) ? exp_k : 8'h00);
        chk("q", q, qm);
        chk("resp_valid", resp_valid, (cyc == resp_cyc));
        if (cyc == resp_cyc) begin
            chk("resp_id", resp_id, exp_id);
            chk("resp_q", resp_q, exp_qn);
        end
        if (resp_valid === 1'b1) begin
            last_resp_id = resp_id;
            last_resp_q  = resp_q;
        end
        for (int i = 0; i < NREQ; i++)
            if (req_ready[i] === 1'b1) begin
                gq.push_back(i);
                gc.push_back(cyc);
            end
        if (cyc == apply_cyc) qm = exp_qn;
        if (g >= 0) begin
            apply_cyc = cyc + 1;
            resp_cyc  = cyc + 2;
            next_free = cyc + 3;
            exp_j  = (opa[g] == SET || opa[g] == TOG) ? mska[g] : 8'h00;
            exp_k  = (opa[g] == RST || opa[g] == TOG) ? mska[g] : 8'h00;
            exp_qn = bank_after(qm, opa[g], mska[g]);
            exp_id = g;
            ptr    = (g + 1) % NREQ;
        end
        drop_g = g;
        cyc++;
        @(posedge clk);
        #1;
        if (drop_g >= 0) begin
            if (keep_all) begin
                opa[drop_g]  = 2'($urandom);
                mska[drop_g] = 8'($urandom);
            end else begin
                vld[drop_g] = 1'b0;
            end
        end
        if (rnd_mode)
            for (int i = 0; i < NREQ; i++)
                if (!vld[i] && $urandom_range(3) == 0) begin
                    vld[i]  = 1'b1;
                    opa[i]  = 2'($urandom);
                    mska[i] = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
                end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        vld       = '0;
        keep_all  = 1'b0;
        rnd_mode  = 1'b0;
        qm        = 8'h00;
        ptr       = 0;
        cyc       = 0;
        apply_cyc = -1;
        resp_cyc  = -1;
        next_free = 0;
        repeat (2) @(negedge clk);
        chk("rst_q", q, 8'h00);
        chk("rst_req_ready", req_ready, 4'h0);
        chk("rst_j_out", j_out, 8'h00);
        chk("rst_k_out", k_out, 8'h00);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_id", resp_id, 2'd0);
        chk("rst_resp_q", resp_q, 8'h00);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && vld != '0; n++) cycle();
        repeat (3) cycle();
        chk("drain_done", vld, 4'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        vld   = '0;
        for (int i = 0; i < NREQ; i++) begin
            opa[i]  = HOLD;
            mska[i] = 8'h00;
        end
`ifdef JK_BANK_SCHED_FIXED_PRI_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        do_reset();

        // Requester 1: set low nibble
        opa[1] = SET; mska[1] = 8'h0F; vld[1] = 1'b1;
        last_resp_q = 'x; last_resp_id = 'x;
        repeat (4) cycle();
        chk("set_resp_id", last_resp_id, 2'd1);
        chk("set_resp_q", last_resp_q, 8'h0F);
        chk("set_q", q, 8'h0F);

        // Requester 2: toggle all
        opa[2] = TOG; mska[2] = 8'hFF; vld[2] = 1'b1;
        last_resp_q = 'x; last_resp_id = 'x;
        repeat (4) cycle();
        chk("tog_resp_id", last_resp_id, 2'd2);
        chk("tog_resp_q", last_resp_q, 8'hF0);

        // All requesters continuously valid
        do_reset();
        gq.delete(); gc.delete();
        keep_all = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            vld[i] = 1'b1; opa[i] = 2'($urandom); mska[i] = 8'($urandom);
        end
        repeat (14) cycle();
        keep_all = 1'b0;
        drain();
        for (int k = 0; k < 5; k++)
            chk("grant_order", (k < gq.size()) ? gq[k] : -1, exp_order[k]);
        for (int k = 0; k < 4; k++)
            chk("grant_spacing", (k + 1 < gc.size()) ? gc[k+1] - gc[k] : -1, 3);

        // Zero mask leaves bank untouched
        do_reset();
        opa[0] = SET; mska[0] = 8'hAA; vld[0] = 1'b1;
        repeat (4) cycle();
        opa[3] = RST; mska[3] = 8'h00; vld[3] = 1'b1;
        last_resp_q = 'x; last_resp_id = 'x;
        repeat (4) cycle();
        chk("mask0_resp_id", last_resp_id, 2'd3);
        chk("mask0_resp_q", last_resp_q, 8'hAA);
        chk("mask0_q", q, 8'hAA);

        // Reset while a set-all command is being applied
        opa[1] = SET; mska[1] = 8'hFF; vld[1] = 1'b1;
        cycle();
        #1;
        chk("apply_j_out", j_out, 8'hFF);
        chk("apply_k_out", k_out, 8'h00);
        rst_n = 1'b0;
        #1;
        chk("midrst_q", q, 8'h00);
        chk("midrst_resp_valid", resp_valid, 1'b0);
        chk("midrst_j_out", j_out, 8'h00);
        do_reset();
        gq.delete(); gc.delete();
        for (int i = 0; i < NREQ; i++) begin
            vld[i] = 1'b1; opa[i] = 2'($urandom); mska[i] = 8'($urandom);
        end
        cycle();
        chk("post_rst_first_grant", (gq.size() > 0) ? gq[0] : -1, 0);
        chk("post_rst_grant_cycle", (gc.size() > 0) ? gc[0] : -1, 0);
        drain();

        // Random traffic
        rnd_mode = 1'b1;
        repeat (300) cycle();
        rnd_mode = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
